// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and defaults for the cacheline arbiter between the I/D caches and main memory.
// Line and address defaults match the cache packages so the widths line up end to end.
package cacheline_arbiter_pkg;

  localparam int DEFAULT_LINE_W = 256;
  localparam int DEFAULT_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

  // Round-robin pick: a tie goes to whichever client was not served last.
  function automatic arb_grant_t pick_winner(input logic i_req, input logic d_req,
                                             input arb_grant_t last_grant);
    arb_grant_t winner;
    if (i_req && d_req) begin
      winner = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req) begin
      winner = GRANT_D;
    end else begin
      winner = GRANT_I;
    end
    return winner;
  endfunction

endpackage

// File: rtl/cacheline_arbiter.sv
// Multiplexes I-cache line reads and D-cache line reads/writebacks onto one memory port.
// One transaction at a time, round-robin on ties, with one idle bubble between grants.
module cacheline_arbiter
  import cacheline_arbiter_pkg::*;
#(
  parameter int LINE_W = DEFAULT_LINE_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t  state;
  arb_grant_t  last_grant;
  arb_grant_t  winner;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_we;
  logic              i_req;
  logic              d_req;
  logic              busy;

  assign i_req  = i_pmem_read;
  assign d_req  = d_pmem_read | d_pmem_write;
  assign winner = pick_winner(i_req, d_req, last_grant);
  assign busy   = (state != IDLE);

  // Requests are only looked at in IDLE, so a finishing client always gets one
  // cycle to drop its request before the next arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            last_grant <= winner;
            if (winner == GRANT_D) begin
              state     <= D_BUSY;
              lat_addr  <= d_pmem_address;
              lat_wdata <= d_pmem_wdata;
              lat_we    <= d_pmem_write;
            end else begin
              state     <= I_BUSY;
              lat_addr  <= i_pmem_address;
              lat_wdata <= '0;
              lat_we    <= 1'b0;
            end
          end
        end
        I_BUSY, D_BUSY: begin
          if (pmem_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and address come from registers only; client resps pass pmem_resp through.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    if (busy) begin
      pmem_read    = ~lat_we;
      pmem_write   = lat_we;
      pmem_address = lat_addr;
      pmem_wdata   = lat_wdata;
    end
    if (state == I_BUSY) begin
      i_pmem_resp = pmem_resp;
    end
    if (state == D_BUSY) begin
      d_pmem_resp = pmem_resp;
    end
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  // A D-cache read and write raised together is a cache bug; it is served as a writeback.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(d_pmem_read && d_pmem_write))
        else $warning("d_pmem_read and d_pmem_write both set, serving as writeback");
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed self-checking bench for cacheline_arbiter; the bench plays both caches and memory.
module tb_cacheline_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int passes = 0;
  int total  = 0;

  cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [LINE_W-1:0] observed,
                              input logic [LINE_W-1:0] expected);
    total++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic check_idle_strobes(input string tag);
    check_output({tag, ".read"}, pmem_read, 1'b0);
    check_output({tag, ".write"}, pmem_write, 1'b0);
  endtask

  task automatic apply_stimulus(input logic ir, input logic [ADDR_W-1:0] ia,
                                input logic dr, input logic dw,
                                input logic [ADDR_W-1:0] da, input logic [LINE_W-1:0] dwd);
    i_pmem_read    = ir;
    i_pmem_address = ia;
    d_pmem_read    = dr;
    d_pmem_write   = dw;
    d_pmem_address = da;
    d_pmem_wdata   = dwd;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout before end of sequence");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [LINE_W-1:0] pat_a5;
    logic [LINE_W-1:0] pat_12;
    logic [LINE_W-1:0] pat_c3;
    int i_count;
    int d_count;
    pat_a5 = {32{8'hA5}};
    pat_12 = {8{32'h1234_5678}};
    pat_c3 = {32{8'hC3}};

    // Reset: every output low, rdata follows memory.
    rst = 1'b1;
    pmem_resp = 1'b0;
    pmem_rdata = pat_c3;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_idle_strobes("reset");
    check_output("reset.addr", pmem_address, '0);
    check_output("reset.wdata", pmem_wdata, '0);
    check_output("reset.i_resp", i_pmem_resp, 1'b0);
    check_output("reset.d_resp", d_pmem_resp, 1'b0);
    check_output("reset.i_rdata", i_pmem_rdata, pat_c3);
    check_output("reset.d_rdata", d_pmem_rdata, pat_c3);

    // Lone I read, memory answers on the fourth strobe cycle.
    apply_stimulus(1'b1, 32'h0000_0060, 1'b0, 1'b0, '0, '0);
    tick();
    check_output("iread.read", pmem_read, 1'b1);
    check_output("iread.write", pmem_write, 1'b0);
    check_output("iread.addr", pmem_address, 32'h60);
    check_output("iread.wdata", pmem_wdata, '0);
    check_output("iread.early_resp", i_pmem_resp, 1'b0);
    tick();
    tick();
    check_output("iread.held", pmem_read, 1'b1);
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = pat_a5;
    #1;
    check_output("iread.i_resp", i_pmem_resp, 1'b1);
    check_output("iread.d_resp", d_pmem_resp, 1'b0);
    check_output("iread.rdata", i_pmem_rdata, pat_a5);
    tick();
    pmem_resp = 1'b0;
    i_pmem_read = 1'b0;
    #1;
    check_output("iread.resp_off", i_pmem_resp, 1'b0);
    check_idle_strobes("iread.bubble");

    // Lone D writeback.
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, 32'h8000_0020, pat_12);
    tick();
    check_output("dwb.write", pmem_write, 1'b1);
    check_output("dwb.read", pmem_read, 1'b0);
    check_output("dwb.addr", pmem_address, 32'h8000_0020);
    check_output("dwb.wdata", pmem_wdata, pat_12);
    pmem_resp = 1'b1;
    #1;
    check_output("dwb.d_resp", d_pmem_resp, 1'b1);
    check_output("dwb.i_resp", i_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    d_pmem_write = 1'b0;
    #1;
    check_output("dwb.resp_off", d_pmem_resp, 1'b0);
    check_idle_strobes("dwb.after");
    tick();
    check_idle_strobes("dwb.idle");

    // Tie right after reset: D first, then I after the bubble.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    apply_stimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, '0);
    tick();
    check_output("tie.first_addr", pmem_address, 32'h200);
    check_output("tie.first_read", pmem_read, 1'b1);
    pmem_resp = 1'b1;
    #1;
    check_output("tie.d_resp", d_pmem_resp, 1'b1);
    check_output("tie.i_quiet", i_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    d_pmem_read = 1'b0;
    #1;
    check_idle_strobes("tie.bubble");
    tick();
    check_output("tie.second_addr", pmem_address, 32'h100);
    check_output("tie.second_read", pmem_read, 1'b1);
    pmem_resp = 1'b1;
    #1;
    check_output("tie.i_resp", i_pmem_resp, 1'b1);
    tick();
    pmem_resp = 1'b0;
    #1;
    check_idle_strobes("tie.bubble2");

    // Sustained contention: last grant was I, so D, I, D, I, D, I.
    apply_stimulus(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0400, '0);
    i_count = 0;
    d_count = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      check_output($sformatf("rr%0d.addr", n), pmem_address,
                   (n % 2 == 0) ? 32'h400 : 32'h300);
      pmem_resp = 1'b1;
      #1;
      if (i_pmem_resp) i_count++;
      if (d_pmem_resp) d_count++;
      check_output($sformatf("rr%0d.d_resp", n), d_pmem_resp, (n % 2 == 0));
      check_output($sformatf("rr%0d.i_resp", n), i_pmem_resp, (n % 2 == 1));
      tick();
      pmem_resp = 1'b0;
      if (n == 5) begin
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
      end
      #1;
      check_idle_strobes($sformatf("rr%0d.bubble", n));
    end
    check_output("rr.i_count", i_count, 3);
    check_output("rr.d_count", d_count, 3);
    tick();
    check_idle_strobes("rr.quiet");

    // Stray resp in IDLE is ignored.
    pmem_resp = 1'b1;
    #1;
    check_output("stray.i_resp", i_pmem_resp, 1'b0);
    check_output("stray.d_resp", d_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    #1;
    check_idle_strobes("stray.idle");

    // Read+write together is a write; address change mid-flight is ignored.
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, 32'h0000_0500, pat_c3);
    tick();
    check_output("illegal.write", pmem_write, 1'b1);
    check_output("illegal.read", pmem_read, 1'b0);
    d_pmem_address = 32'h0000_0600;
    d_pmem_wdata = pat_a5;
    tick();
    check_output("midchg.addr", pmem_address, 32'h500);
    check_output("midchg.wdata", pmem_wdata, pat_c3);
    pmem_resp = 1'b1;
    #1;
    check_output("illegal.d_resp", d_pmem_resp, 1'b1);
    tick();
    pmem_resp = 1'b0;
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
    #1;
    check_idle_strobes("illegal.after");

    // Request dropped before its resp still completes.
    apply_stimulus(1'b1, 32'h0000_0700, 1'b0, 1'b0, '0, '0);
    tick();
    i_pmem_read = 1'b0;
    tick();
    check_output("drop.addr", pmem_address, 32'h700);
    pmem_resp = 1'b1;
    #1;
    check_output("drop.i_resp", i_pmem_resp, 1'b1);
    tick();
    pmem_resp = 1'b0;
    #1;
    check_idle_strobes("drop.after");

    // Reset two cycles into an I transaction, then a late resp.
    apply_stimulus(1'b1, 32'h0000_0060, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check_output("rstmid.busy", pmem_read, 1'b1);
    rst = 1'b1;
    i_pmem_read = 1'b0;
    tick();
    check_idle_strobes("rstmid.strobes");
    check_output("rstmid.addr", pmem_address, '0);
    rst = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check_output("rstmid.late_i", i_pmem_resp, 1'b0);
    check_output("rstmid.late_d", d_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    apply_stimulus(1'b1, 32'h0000_0800, 1'b1, 1'b0, 32'h0000_0900, '0);
    tick();
    check_output("rstmid.tie_addr", pmem_address, 32'h900);
    pmem_resp = 1'b1;
    #1;
    check_output("rstmid.tie_d_resp", d_pmem_resp, 1'b1);
    tick();
    pmem_resp = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
